// File: rtl/ans_pkg.sv
// Shared ANS constants and the histogram-builder state type.
package ans_pkg;

  localparam int SYM_WIDTH = 4;
  localparam int CNT_WIDTH = 4;
  localparam int SYM_COUNT = 2 ** SYM_WIDTH;

  typedef enum logic [1:0] {
    ST_COUNT = 2'd0,
    ST_SCAN  = 2'd1,
    ST_NORM  = 2'd2,
    ST_EMIT  = 2'd3
  } freq_state_e;

endpackage

// File: rtl/ans_count_scale.sv
// Scales one raw histogram value down to an emitted count, with an optional
// floor of 1 so any symbol that occurred keeps a nonzero frequency.
module ans_count_scale #(
  parameter int HIST_WIDTH = 8,
  parameter int CNT_WIDTH  = 4,
  parameter int SHIFT_W    = 3
) (
  input  logic [HIST_WIDTH-1:0] hist_i,
  input  logic [SHIFT_W-1:0]    shift_i,
  input  logic                  floor_en_i,
  output logic [CNT_WIDTH-1:0]  cnt_o
);

  always_comb begin
    cnt_o = CNT_WIDTH'(hist_i >> shift_i);
    if (floor_en_i && (hist_i != '0) && (cnt_o == '0)) begin
      cnt_o = CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/ans_freq_builder.sv
// Histogram builder: counts a block of symbols, normalizes to CNT_WIDTH and
// streams the table in index order. Define ANS_FREQ_MIN_ONE_EN to floor seen symbols at 1.
module ans_freq_builder
  import ans_pkg::*;
#(
  parameter int HIST_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [SYM_WIDTH-1:0] in_i,
  input  logic                 in_vld_i,
  input  logic                 in_last_i,
  output logic                 in_rdy_o,
  output logic [CNT_WIDTH-1:0] out_o,
  output logic                 out_vld_o,
  input  logic                 out_rdy_i,
  output logic                 busy_o
);

  localparam int SHIFT_MAX = HIST_WIDTH - CNT_WIDTH;
  localparam int SHIFT_W   = (SHIFT_MAX < 1) ? 1 : $clog2(SHIFT_MAX + 1);
  localparam int CNT_MAX   = (2 ** CNT_WIDTH) - 1;

`ifdef ANS_FREQ_MIN_ONE_EN
  localparam logic FLOOR_EN = 1'b1;
`else
  localparam logic FLOOR_EN = 1'b0;
`endif

  freq_state_e           state_q, state_d;
  logic [HIST_WIDTH-1:0] hist_q [SYM_COUNT];
  logic [HIST_WIDTH-1:0] hist_d [SYM_COUNT];
  logic [SYM_WIDTH-1:0]  idx_q, idx_d;
  logic [HIST_WIDTH-1:0] max_q, max_d;
  logic [SHIFT_W-1:0]    shift_q, shift_d;
  logic [CNT_WIDTH-1:0]  out_q, out_d;
  logic                  out_vld_q, out_vld_d;

  logic [SHIFT_W-1:0]    shift_srch;
  logic [SYM_WIDTH-1:0]  scale_idx;
  logic [SHIFT_W-1:0]    scale_shift;
  logic [CNT_WIDTH-1:0]  scale_cnt;

  // Smallest shift that brings the peak count into CNT_WIDTH bits.
  always_comb begin
    shift_srch = SHIFT_W'(SHIFT_MAX);
    for (int k = SHIFT_MAX; k >= 0; k--) begin
      if ((max_q >> k) <= HIST_WIDTH'(CNT_MAX)) begin
        shift_srch = SHIFT_W'(k);
      end
    end
  end

  // The scaler always looks at the entry that out_q will show after this edge.
  assign scale_idx   = (state_q == ST_NORM) ? '0 : idx_q + 1'b1;
  assign scale_shift = (state_q == ST_NORM) ? shift_srch : shift_q;

  ans_count_scale #(
    .HIST_WIDTH(HIST_WIDTH),
    .CNT_WIDTH (CNT_WIDTH),
    .SHIFT_W   (SHIFT_W)
  ) u_scale (
    .hist_i    (hist_q[scale_idx]),
    .shift_i   (scale_shift),
    .floor_en_i(FLOOR_EN),
    .cnt_o     (scale_cnt)
  );

  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    idx_d     = idx_q;
    max_d     = max_q;
    shift_d   = shift_q;
    out_d     = out_q;
    out_vld_d = out_vld_q;

    unique case (state_q)
      ST_COUNT: begin
        if (in_vld_i) begin
          if (hist_q[in_i] != '1) begin
            hist_d[in_i] = hist_q[in_i] + 1'b1;
          end
          if (in_last_i) begin
            state_d = ST_SCAN;
            idx_d   = '0;
            max_d   = '0;
          end
        end
      end
      ST_SCAN: begin
        if (hist_q[idx_q] > max_q) begin
          max_d = hist_q[idx_q];
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == SYM_WIDTH'(SYM_COUNT - 1)) begin
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        shift_d   = shift_srch;
        idx_d     = '0;
        state_d   = ST_EMIT;
        out_vld_d = 1'b1;
        out_d     = scale_cnt;
      end
      ST_EMIT: begin
        if (out_rdy_i) begin
          hist_d[idx_q] = '0;
          idx_d         = idx_q + 1'b1;
          if (idx_q == SYM_WIDTH'(SYM_COUNT - 1)) begin
            state_d   = ST_COUNT;
            out_vld_d = 1'b0;
            out_d     = '0;
          end else begin
            out_d = scale_cnt;
          end
        end
      end
      default: state_d = ST_COUNT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_COUNT;
      idx_q     <= '0;
      max_q     <= '0;
      shift_q   <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      for (int i = 0; i < SYM_COUNT; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      max_q     <= max_d;
      shift_q   <= shift_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      hist_q    <= hist_d;
    end
  end

  assign in_rdy_o  = (state_q == ST_COUNT);
  assign busy_o    = (state_q != ST_COUNT);
  assign out_o     = out_q;
  assign out_vld_o = out_vld_q;

endmodule

// File: tb/tb_ans_freq_builder.sv
// Bench for ans_freq_builder: directed and random blocks against a plain
// histogram/normalize model. Honors ANS_FREQ_MIN_ONE_EN like the design.
module tb_ans_freq_builder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_sym;
  logic       in_vld;
  logic       in_last;
  logic       in_rdy;
  logic [3:0] out;
  logic       out_vld;
  logic       out_rdy;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int exp_t [16];
  int got   [16];
  int blk   = 0;

  always #5 clk = ~clk;

  ans_freq_builder dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .in_i     (in_sym),
    .in_vld_i (in_vld),
    .in_last_i(in_last),
    .in_rdy_o (in_rdy),
    .out_o    (out),
    .out_vld_o(out_vld),
    .out_rdy_i(out_rdy),
    .busy_o   (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: saturating histogram, peak-based shift, truncate, optional floor.
  task automatic model(input int syms[$]);
    int h [16];
    int mx;
    int sh;
    foreach (h[i]) h[i] = 0;
    foreach (syms[i]) if (h[syms[i]] < 255) h[syms[i]]++;
    mx = 0;
    foreach (h[i]) if (h[i] > mx) mx = h[i];
    sh = 0;
    while ((mx >> sh) > 15) sh++;
    foreach (h[i]) begin
      exp_t[i] = (h[i] >> sh) % 16;
`ifdef ANS_FREQ_MIN_ONE_EN
      if (h[i] != 0 && exp_t[i] == 0) exp_t[i] = 1;
`endif
    end
  endtask

  task automatic send(input int syms[$], input bit gaps, input bit junk);
    for (int i = 0; i < syms.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_vld = 1'b0;
        tick();
      end
      chk("in_rdy_count", in_rdy, 1);
      in_sym  = syms[i][3:0];
      in_vld  = 1'b1;
      in_last = (i == syms.size() - 1);
      tick();
    end
    in_last = 1'b0;
    in_vld  = junk;
    in_sym  = 4'($urandom_range(0, 15));
  endtask

  // Drains entries 0..stop_at-1; stalls stall_len cycles on entry stall_idx.
  task automatic collect(input int stop_at, input int stall_idx, input int stall_len, input bit rnd);
    int   k = 0;
    int   cyc = 0;
    int   stall_left = stall_len;
    bit   prev_stall = 0;
    bit   rdy;
    logic [3:0] held = '0;
    in_vld = 1'b0;
    while (k < stop_at && cyc < 400) begin
      if (out_vld) begin
        if (prev_stall) chk("hold_out", out, held);
        rdy = 1'b1;
        if (k == stall_idx && stall_left > 0) begin
          rdy = 1'b0;
          stall_left--;
          chk("stall_in_rdy", in_rdy, 0);
        end else if (rnd) begin
          rdy = 1'($urandom_range(0, 1));
        end
        out_rdy = rdy;
        if (rdy) begin
          got[k] = out;
          chk($sformatf("b%0d_idx%0d", blk, k), out, exp_t[k]);
          k++;
        end
        prev_stall = !rdy;
        held = out;
      end else begin
        out_rdy = 1'b1;
        prev_stall = 0;
      end
      if (k < stop_at) tick();
      cyc++;
    end
    chk("emit_count", k, stop_at);
    if (stop_at == 16) begin
      out_rdy = 1'b1;
      tick();
      chk("end_out_vld", out_vld, 0);
      chk("end_in_rdy", in_rdy, 1);
      chk("end_busy", busy, 0);
    end
    blk++;
  endtask

  task automatic wait_vld(output int n);
    n = 0;
    while (!out_vld && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int q [$];
    int n;

    rst_n   = 1'b0;
    in_sym  = '0;
    in_vld  = 1'b0;
    in_last = 1'b0;
    out_rdy = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("rst_out", out, 0);
      chk("rst_out_vld", out_vld, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_rdy", in_rdy, 1);
      tick();
    end
    rst_n = 1'b1;
    tick();

    // Small block, junk in_vld during SCAN/NORM must be ignored.
    q = '{3, 3, 3, 7};
    model(q);
    send(q, 0, 1);
    chk("scan_in_rdy", in_rdy, 0);
    chk("scan_busy", busy, 1);
    wait_vld(n);
    chk("latency", n, 17);
    collect(16, -1, 0, 0);
    chk("t1_idx3", got[3], 3);
    chk("t1_idx7", got[7], 1);

    q.delete();
    for (int i = 0; i < 40; i++) q.push_back(5);
    q.push_back(2);
    model(q);
    send(q, 0, 0);
    collect(16, -1, 0, 0);
    chk("t2_idx5", got[5], 10);
`ifdef ANS_FREQ_MIN_ONE_EN
    chk("t2_idx2", got[2], 1);
`else
    chk("t2_idx2", got[2], 0);
`endif

    q.delete();
    for (int i = 0; i < 300; i++) q.push_back(0);
    q.push_back(1);
    model(q);
    send(q, 0, 0);
    collect(16, -1, 0, 0);
    chk("t3_idx0", got[0], 15);
`ifdef ANS_FREQ_MIN_ONE_EN
    chk("t3_idx1", got[1], 1);
`else
    chk("t3_idx1", got[1], 0);
`endif

    // Backpressure at idx 4.
    q.delete();
    for (int i = 0; i < 30; i++) q.push_back(int'($urandom_range(0, 15)));
    q.push_back(4);
    model(q);
    send(q, 1, 0);
    collect(16, 4, 5, 0);

    // Reset in the middle of emission, then a fresh single-symbol block.
    q.delete();
    for (int i = 0; i < 25; i++) q.push_back(int'($urandom_range(0, 15)));
    model(q);
    send(q, 0, 0);
    collect(8, -1, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_vld", out_vld, 0);
    chk("mid_rst_out", out, 0);
    chk("mid_rst_busy", busy, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    q = '{9};
    model(q);
    send(q, 0, 0);
    collect(16, -1, 0, 0);
    chk("t5_idx9", got[9], 1);
    chk("t5_idx8", got[8], 0);

    // Random back-to-back blocks with gaps and random out_rdy.
    for (int b = 0; b < 8; b++) begin
      q.delete();
      n = int'($urandom_range(1, 120));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 2) == 0) q.push_back(int'($urandom_range(0, 3)));
        else q.push_back(int'($urandom_range(0, 15)));
      end
      model(q);
      send(q, 1, 1);
      collect(16, -1, 0, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
